// File: rtl/nand_tristate_bus_driver.sv
// -----------------------------------------------------------------------------
// nand_tristate_bus_driver
//
// Purpose:
//   CHANNELS independent WIDTH-input NAND channels share one tri-state bus
//   line. A round-robin arbiter picks the owner. The owner's NAND result is
//   registered and driven onto the bus. Between two owners the bus is left
//   at Z for TURNAROUND cycles (break-before-make).
//
// Optional feature (macro OWNER_TIMEOUT_EN):
//   When defined, an owner is forced off the bus after MAX_HOLD consecutive
//   DRIVE cycles. timeout pulses for one cycle on each forced release. When
//   undefined, an owner holds the bus for as long as its req stays high and
//   timeout is tied to 0.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   in_data  in   CHANNELS*WIDTH, channel k inputs at [k*WIDTH +: WIDTH]
//   req      in   CHANNELS, level-sensitive bus request per channel
//   bus_out  out  registered NAND of the owner's inputs, Z when no owner
//   grant    out  CHANNELS, one-hot current owner, 0 when none
//   owner    out  index of current/last owner
//   busy     out  high in DRIVE or TURN
//   timeout  out  1-cycle pulse on forced release
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner, bus Z, arbitrate every cycle
// DRIVE | owner drives registered NAND onto the bus
// TURN  | bus Z for TURNAROUND cycles after an owner lets go
// -----------------------------------------------------------------------------
module nand_tristate_bus_driver #(
  parameter int WIDTH      = 3,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 8,
  localparam int OW        = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       req,
  output wire                       bus_out,
  output logic [CHANNELS-1:0]       grant,
  output logic [OW-1:0]             owner,
  output logic                      busy,
  output logic                      timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  localparam logic [3:0]    TURN_LOAD = 4'(TURNAROUND - 1);
  localparam logic [OW-1:0] LAST_CH   = OW'(CHANNELS - 1);

  // Elaboration-time parameter range checks.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH out of range 2..16");
  end
  if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS out of range 2..16");
  end
  if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
    $error("TURNAROUND out of range 1..15");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD out of range 1..255");
  end

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          data_q, data_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [CHANNELS-1:0] nand_v;
  logic                pick_valid;
  logic [OW-1:0]       pick_idx;
  logic [OW-1:0]       next_ptr;
  logic                do_grant;
  logic                do_release;
  logic                force_release;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      nand_v[k] = ~&in_data[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: walk from the farthest candidate back to the pointer so
  // the last match written is the closest set req at or after ptr_q.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      logic [OW:0]   sum;
      logic [OW-1:0] cand;
      sum = {1'b0, ptr_q} + (OW+1)'(i);
      if (sum >= (OW+1)'(CHANNELS)) begin
        sum = sum - (OW+1)'(CHANNELS);
      end
      cand = sum[OW-1:0];
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign next_ptr = (owner_q == LAST_CH) ? '0 : owner_q + 1'b1;

`ifdef OWNER_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // hold_q counts DRIVE cycles already completed by the current owner, so the
  // release fires at the end of the MAX_HOLD-th DRIVE cycle.
  assign force_release = (hold_q == HOLD_LAST);

  always_comb begin
    hold_d = hold_q;
    if (do_grant) begin
      hold_d = '0;
    end else if (state_q == S_DRIVE && !do_release) begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign force_release = 1'b0;
`endif

  always_comb begin
    do_grant   = 1'b0;
    do_release = 1'b0;
    case (state_q)
      S_IDLE:  do_grant   = pick_valid;
      S_DRIVE: do_release = !req[owner_q] || force_release;
      S_TURN:  do_grant   = (cnt_q == 4'd0) && pick_valid;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (do_grant) begin
          state_d = S_DRIVE;
          owner_d = pick_idx;
          data_d  = nand_v[pick_idx];
        end
      end
      S_DRIVE: begin
        if (do_release) begin
          state_d   = S_TURN;
          cnt_d     = TURN_LOAD;
          ptr_d     = next_ptr;
          // A voluntary drop on the same edge as the limit is not a timeout.
          timeout_d = req[owner_q] && force_release;
        end else begin
          data_d = nand_v[owner_q];
        end
      end
      S_TURN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (do_grant) begin
          state_d = S_DRIVE;
          owner_d = pick_idx;
          data_d  = nand_v[pick_idx];
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      data_q    <= 1'b1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode from registered state only, so an asynchronous reset
  // releases the bus and clears grant without waiting for a clock edge.
  always_comb begin
    grant = '0;
    if (state_q == S_DRIVE) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign owner   = owner_q;
  assign busy    = (state_q != S_IDLE);
  assign bus_out = (state_q == S_DRIVE) ? data_q : 1'bz;

`ifdef OWNER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nand_tristate_bus_driver.sv
module tb_nand_tristate_bus_driver;

  localparam int W  = 3;
  localparam int CH = 4;
  localparam int TA = 3;
  localparam int MH = 4;
`ifdef OWNER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0]   req = '0;

  // Two identical DUTs, one bus pulled up and one pulled down: a released bus
  // reads 1 on the first and 0 on the second, a driven bus reads the same.
  wire bus_up, bus_dn;
  pullup   (bus_up);
  pulldown (bus_dn);

  logic [CH-1:0] grant, grant_b;
  logic [1:0]    owner, owner_b;
  logic          busy, busy_b, tmo, tmo_b;

  always #5 clk = ~clk;

  nand_tristate_bus_driver #(.WIDTH(W), .CHANNELS(CH), .TURNAROUND(TA), .MAX_HOLD(MH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .req(req),
    .bus_out(bus_up), .grant(grant), .owner(owner), .busy(busy), .timeout(tmo));

  nand_tristate_bus_driver #(.WIDTH(W), .CHANNELS(CH), .TURNAROUND(TA), .MAX_HOLD(MH)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .req(req),
    .bus_out(bus_dn), .grant(grant_b), .owner(owner_b), .busy(busy_b), .timeout(tmo_b));

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus, how many Z cycles remain, whose turn.
  int m_own;     // -1 when nobody drives
  bit m_turn;
  int m_gap;
  int m_ptr;
  int m_last;
  bit m_data;
  int m_hold;
  bit m_to;
  int prev_drv;  // owner driving in the previous sampled cycle, -1 if none

  function automatic bit nand_of(int c);
    logic [W-1:0] v;
    v = in_data[c*W +: W];
    return ~&v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_turn = 0; m_gap = 0; m_ptr = 0; m_last = 0;
    m_data = 1'b1; m_hold = 0; m_to = 0; prev_drv = -1;
  endtask

  task automatic model_arbitrate();
    m_turn = 0;
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (m_ptr + i) % CH;
      if (req[c]) begin
        m_own = c; m_last = c; m_hold = 0; m_data = nand_of(c);
        break;
      end
    end
  endtask

  task automatic model_release();
    m_ptr = (m_own + 1) % CH;
    m_own = -1; m_turn = 1; m_gap = TA - 1;
  endtask

  task automatic model_update();
    m_to = 0;
    if (m_own >= 0) begin
      if (!req[m_own]) model_release();
      else if (TO_EN && (m_hold + 1 == MH)) begin
        m_to = 1;
        model_release();
      end else begin
        m_hold++;
        m_data = nand_of(m_own);
      end
    end else if (m_turn) begin
      if (m_gap == 0) model_arbitrate();
      else m_gap--;
    end else begin
      model_arbitrate();
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] eg;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("grant", 32'(grant), 32'(eg));
    chk("owner", 32'(owner), 32'(m_last));
    chk("busy", 32'(busy), 32'((m_own >= 0) || m_turn));
    chk("timeout", 32'(tmo), 32'(m_to));
    chk("bus_pullup", 32'(bus_up), 32'((m_own >= 0) ? m_data : 1'b1));
    chk("bus_pulldown", 32'(bus_dn), 32'((m_own >= 0) ? m_data : 1'b0));
    // Break-before-make: two back-to-back driven cycles keep one owner.
    if (grant != '0) begin
      if (prev_drv >= 0) chk("break_before_make", 32'(owner), 32'(prev_drv));
      prev_drv = int'(owner);
    end else begin
      prev_drv = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    in_data[c*W +: W] = v;
  endtask

  task automatic wait_grant(input string tag, input int exp_ch, input int bound);
    logic [CH-1:0] eg;
    int n;
    n = 0;
    while (grant == '0 && n < bound) begin
      tick();
      n++;
    end
    eg = '0;
    eg[exp_ch] = 1'b1;
    chk(tag, 32'(grant), 32'(eg));
  endtask

  initial begin
    int pulses;
    model_reset();
    in_data = 12'($urandom);
    #2;
    check_all();
    do_reset();

    // Single requester, 1-cycle NAND latency.
    set_ch(0, 3'b101);
    req = 4'b0001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_bus", 32'(bus_up), 32'h1);
    set_ch(0, 3'b111);
    tick();
    chk("t1_bus_nand0", 32'(bus_dn), 32'h0);

    // Two requesters from reset: ch1 first, then exactly TA Z cycles, then ch2.
    do_reset();
    req = 4'b0110;
    tick();
    chk("t2_owner1", 32'(owner), 32'h1);
    req = 4'b0100;
    for (int i = 0; i < TA; i++) begin
      tick();
      chk("t2_gap_grant", 32'(grant), 32'h0);
      chk("t2_gap_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("t2_owner2", 32'(owner), 32'h2);
    chk("t2_grant2", 32'(grant), 32'h4);

    // Owner drops on the same edge another channel rises: TURN first.
    req = 4'b1000;
    for (int i = 0; i < TA; i++) begin
      tick();
      chk("t3_gap_grant", 32'(grant), 32'h0);
      chk("t3_gap_bus", 32'(bus_up), 32'h1);
    end
    tick();
    chk("t3_grant3", 32'(grant), 32'h8);

    // All requesting, each owner lets go after 2 DRIVE cycles.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t4_rr_order", k % CH, 2 * TA + 4);
      tick();
      req[k % CH] = 1'b0;
      tick();
      req = 4'b1111;
    end

    // Async reset mid-DRIVE with a non-zero pointer.
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0010;
    wait_grant("t5_pre_owner1", 1, TA + 3);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t5_async_grant", 32'(grant), 32'h0);
    chk("t5_async_bus_dn", 32'(bus_dn), 32'h0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_ptr_restart", 32'(grant), 32'h1);
    do_reset();
    req = 4'b1000;
    tick();
    chk("t5_ch3", 32'(grant), 32'h8);

    // Owner holding its request with a competitor waiting.
    do_reset();
    req = 4'b0011;
    tick();
    chk("t6_grant0", 32'(grant), 32'h1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tmo === 1'b1) pulses++;
    end
    chk("t6_timeout_pulses", 32'(pulses), TO_EN ? 32'd1 : 32'd0);
    chk("t6_final_grant", 32'(grant), TO_EN ? 32'h2 : 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_data = 12'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if (n == 300) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nand_tristate_bus_driver.md
Name: nand_tristate_bus_driver

Overview:
- Parametrised successor of the single 3-input tri-state NAND cell.
- CHANNELS independent WIDTH-input NAND channels share one tri-state output line through a round-robin arbiter.
- A break-before-make turnaround guarantees Z between owners, and the output is registered.
- Sits between gate-level datapath cells and a shared wired bus line.

Parameters:
WIDTH, 3, NAND inputs per channel (2..16)
CHANNELS, 4, number of requesting channels (2..16)
TURNAROUND, 1, Z cycles inserted between owners (1..15)
MAX_HOLD, 8, max consecutive DRIVE cycles per grant (used only with OWNER_TIMEOUT_EN; 1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  CHANNELS*WIDTH  channel k inputs at [k*WIDTH +: WIDTH]
req  input  CHANNELS  per-channel bus request, level-sensitive
bus_out  output(tri)  1  registered NAND of owner inputs, else Z
grant  output  CHANNELS  one-hot current owner, 0 when none
owner  output  max(1,$clog2(CHANNELS))  index of current/last owner
busy  output  1  high in DRIVE or TURN
timeout  output  1  1-cycle pulse on forced release (0 without macro)

Behaviour:
- One clock. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state IDLE; grant=0; owner=0; busy=0; timeout=0; bus_out=Z.
  - RR pointer=0, so channel 0 has top priority first.
  - Output data register=1.
- FSM states:
  - IDLE: bus Z, grant=0.
    - If any req, pick the first set req scanning from the pointer upward with wrap.
    - Next cycle: DRIVE, grant one-hot, owner=index.
  - DRIVE:
    - Each cycle, data_reg <= ~&in_data[owner]. bus_out = data_reg.
    - Entry cycle: bus_out shows the NAND of inputs sampled on the granting edge, i.e. 1-cycle latency from inputs to bus.
    - While req[owner]=1, stay.
    - When req[owner]=0 at an edge: go TURN, grant=0, bus Z that same cycle.
    - Pointer <= owner+1 mod CHANNELS.
  - TURN:
    - Bus Z, grant=0, busy=1.
    - Down-counter loaded with TURNAROUND-1. Leave when it reaches 0.
    - Exit to arbitration exactly as in IDLE: DRIVE if any req, else IDLE.
    - req changes during TURN are ignored until exit.
- Break-before-make: never two consecutive DRIVE cycles with different owners. Minimum Z gap = TURNAROUND cycles.
- Simultaneous requests: resolved round-robin. A single requester is re-granted after TURN.
- The owner's req drop and another req rise on the same edge: TURN first, no skip.
- Reset mid-DRIVE: bus goes Z and grant clears immediately (asynchronous), pointer returns to 0.
- in_data changes on non-owner channels have no effect on bus_out.

Optional Feature:
- Macro: OWNER_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter is cleared on DRIVE entry and increments each DRIVE cycle.
  - When it reaches MAX_HOLD with req[owner] still high: forced transition to TURN, timeout=1 for one cycle, pointer advances past the owner.
  - The owner may be re-granted later via round-robin.
- Undefined:
  - No counter.
  - An owner holds indefinitely while req is high.
  - timeout is tied to 0.

Test Plan:
- Reset then req=4'b0001, in_data ch0=3'b101 -> grant=0001 the cycle after req. bus_out=1 on the next cycle. ch0 set to 3'b111 -> bus_out=0 one cycle later.
- req=4'b0110 from IDLE after reset -> ch1 granted first. Drop req[1] -> exactly TURNAROUND Z cycles, then ch2 granted, owner=2.
- TURNAROUND=3, owner drops req while ch3 requests -> bus Z for exactly 3 cycles, grant=0 throughout, then grant=1000.
- All req=1, each owner releasing after 2 cycles -> grant order 0,1,2,3,0 with wrap, and one Z gap between each.
- Assert rst_n=0 asynchronously mid-DRIVE -> bus Z and grant=0 before the next clock edge. After release with req=1000 -> pointer restarts at 0 and ch3 is still granted.
- OWNER_TIMEOUT_EN with MAX_HOLD=4, req[0] held high, req[1]=1 -> ch0 drives 4 cycles, timeout pulses once, TURN follows, then ch1 granted.
- Same stimulus without the macro -> ch0 never released and timeout stays 0.
